// File: rtl/cam_match_array.sv
`default_nettype none
// ============================================================================
// Module      : cam_match_array
// Description : CAM storage and parallel compare stage. Holds DEPTH keys with
//               valid bits and produces a registered multi-hot match vector.
//               Optional macro CAM_MATCH_WR_BYPASS_EN forwards a same-cycle
//               write/invalidate/flush into the concurrent search.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_match_array #(
    parameter int KEY_WIDTH  = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = (1 << ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [KEY_WIDTH-1:0]  wr_key,
    input  logic                  wr_valid,
    input  logic                  flush,
    input  logic                  search_en,
    input  logic [KEY_WIDTH-1:0]  search_key,
    output logic                  match_valid,
    output logic [DEPTH-1:0]      match_out,
    output logic [ADDR_WIDTH:0]   entry_count,
    output logic                  full
);

    localparam logic [ADDR_WIDTH:0] c_DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [KEY_WIDTH-1:0] r_key [DEPTH];
    logic [DEPTH-1:0]     r_valid;
    logic [ADDR_WIDTH:0]  r_count;
    logic [DEPTH-1:0]     r_match;
    logic                 r_match_valid;

    logic [DEPTH-1:0]     w_hit;
    logic                 w_cur_valid;
    logic                 w_inc;
    logic                 w_dec;

    // Parallel compare; this is the critical path into the match register.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        localparam logic [ADDR_WIDTH-1:0] c_IDX = ADDR_WIDTH'(i);
        logic w_base_hit;
        assign w_base_hit = r_valid[i] && (r_key[i] == search_key);
`ifdef CAM_MATCH_WR_BYPASS_EN
        assign w_hit[i] = flush ? 1'b0 :
                          (wr_en && (wr_addr == c_IDX)) ? (wr_valid && (wr_key == search_key)) :
                          w_base_hit;
`else
        assign w_hit[i] = w_base_hit;
`endif
    end

    assign w_cur_valid = r_valid[wr_addr];
    assign w_inc       = wr_en &&  wr_valid && !w_cur_valid;
    assign w_dec       = wr_en && !wr_valid &&  w_cur_valid;

    // Key storage carries no reset; a discarded write leaves the key untouched.
    always_ff @(posedge clk) begin
        if (!reset && !flush && wr_en && wr_valid) begin
            r_key[wr_addr] <= wr_key;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            if (wr_en) begin
                r_valid[wr_addr] <= wr_valid;
            end
            if (w_inc) begin
                r_count <= r_count + 1'b1;
            end else if (w_dec) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Idle cycles clear the vector so the downstream stage never sees stale hits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_match_valid <= 1'b0;
            r_match       <= '0;
        end else begin
            r_match_valid <= search_en;
            r_match       <= search_en ? w_hit : '0;
        end
    end

    assign match_valid = r_match_valid;
    assign match_out   = r_match;
    assign entry_count = r_count;
    assign full        = (r_count == c_DEPTH_CNT);

endmodule
`default_nettype wire
